// File: rtl/common_dffram_wrsched_2w_pkg.sv
// common_dffram_wrsched_2w_pkg
//   Shared definitions for the DFF RAM write scheduler: controller state
//   encodings and the RAM depth derivation from the address width.
package common_dffram_wrsched_2w_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Number of RAM entries addressed by an aw-bit address.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/common_dffram_wrsched_2w_if.sv
// common_dffram_wrsched_2w_if
//   Bundles the two write requesters, the clear command, the RAM-side
//   port A / read ports and the client read ports of the scheduler.
//   slave  : the scheduler view
//   master : the environment view (requesters, clients and the RAM)
interface common_dffram_wrsched_2w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic                  ram_ena;
    logic                  ram_wea;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [ADDR_WIDTH-1:0] rdb_addr;
    logic [ADDR_WIDTH-1:0] rdc_addr;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [ADDR_WIDTH-1:0] ram_addrc;
    logic [DATA_WIDTH-1:0] ram_doutb;
    logic [DATA_WIDTH-1:0] ram_doutc;
    logic [DATA_WIDTH-1:0] rdb_data;
    logic [DATA_WIDTH-1:0] rdc_data;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_req, rdb_addr, rdc_addr, ram_doutb, ram_doutc,
        output req0_ready, req1_ready, clr_busy, clr_done,
        output ram_addra, ram_ena, ram_wea, ram_dina,
        output ram_addrb, ram_addrc, rdb_data, rdc_data
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_req, rdb_addr, rdc_addr, ram_doutb, ram_doutc,
        input  req0_ready, req1_ready, clr_busy, clr_done,
        input  ram_addra, ram_ena, ram_wea, ram_dina,
        input  ram_addrb, ram_addrc, rdb_data, rdc_data
    );
endinterface

// File: rtl/common_dffram_wrsched_2w_rr_arbiter.sv
// common_rr_arbiter_2
//   Two-way round-robin arbiter with a same-cycle one-hot grant.
//   clk, reset : clock, asynchronous active-high reset
//   req_i[1:0] : request lines
//   en_i       : arbitration enable; no grant is issued while low
//   grant_o    : one-hot grant
//   The last granted index is remembered; on a conflict the other
//   requester wins. After reset requester 0 wins the first conflict.
module common_rr_arbiter_2
    import common_dffram_wrsched_2w_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (|grant_o) begin
            rr_last_d = grant_o[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/common_dffram_wrsched_2w.sv
// common_dffram_wrsched_2w
//   Write scheduler and read-bypass controller for a DFF RAM with one
//   write port (A) and two combinational read ports (B, C).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave view of common_dffram_wrsched_2w_if
//                - req0/req1 valid/ready write requesters (round robin)
//                - clr_req/clr_busy/clr_done sequenced clear sweep
//                - ram_* port A drive and read port passthrough
//                - rdb/rdc client reads, optionally bypassing port A
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | requesters arbitrated onto port A, clr_req sampled
//   ST_CLEAR | one entry per cycle written with CLR_VALUE, readys low
module common_dffram_wrsched_2w
    import common_dffram_wrsched_2w_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0,
    parameter bit                    BYPASS_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    common_dffram_wrsched_2w_if.slave bus
);

    localparam int                    DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_done_q, clr_done_d;

    logic                  arb_en;
    logic [1:0]            grant;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Reset gates the enable so nothing is granted while reset is held.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    common_rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({bus.req1_valid, bus.req0_valid}),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With no grant the address/data fall back to req0 fields; the write
    // enable is low so their value does not matter.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.req0_addr;
        wr_data = bus.req0_data;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
                wr_data = CLR_VALUE;
            end else if (grant[0]) begin
                wr_en   = 1'b1;
            end else if (grant[1]) begin
                wr_en   = 1'b1;
                wr_addr = bus.req1_addr;
                wr_data = bus.req1_data;
            end
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.clr_busy   = (state_q == ST_CLEAR) && !reset;
    assign bus.clr_done   = clr_done_q;
    assign bus.ram_ena    = wr_en;
    assign bus.ram_wea    = wr_en;
    assign bus.ram_addra  = wr_addr;
    assign bus.ram_dina   = wr_data;
    assign bus.ram_addrb  = bus.rdb_addr;
    assign bus.ram_addrc  = bus.rdc_addr;

    generate
        if (BYPASS_EN) begin : g_bypass
            // The RAM only holds the new word after the edge, so a read of
            // the address being written this cycle takes the write data.
            assign bus.rdb_data = (wr_en && (wr_addr == bus.rdb_addr)) ? wr_data : bus.ram_doutb;
            assign bus.rdc_data = (wr_en && (wr_addr == bus.rdc_addr)) ? wr_data : bus.ram_doutc;
        end else begin : g_no_bypass
            assign bus.rdb_data = bus.ram_doutb;
            assign bus.rdc_data = bus.ram_doutc;
        end
    endgenerate

endmodule

// File: tb/tb_common_dffram_wrsched_2w.sv
module tb_common_dffram_wrsched_2w;

    localparam int DW = 8;
    localparam int AW = 2;

    typedef struct {
        int          who;   // 0 = req0, 1 = req1, 2 = clear sweep
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    wr_t  sb[$];
    logic [DW-1:0] mem [4];

    common_dffram_wrsched_2w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    common_dffram_wrsched_2w #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CLR_VALUE  (8'h00),
        .BYPASS_EN  (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural DFF RAM: synchronous write, combinational reads.
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
    end
    assign bus.ram_doutb = mem[bus.ram_addrb];
    assign bus.ram_doutc = mem[bus.ram_addrc];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic push(input int who, input int addr, input int data);
        wr_t e;
        e.who  = who;
        e.addr = AW'(addr);
        e.data = DW'(data);
        sb.push_back(e);
    endtask

    // Every port A write is matched against the next expected write.
    always @(negedge clk) begin
        if (bus.ram_ena && bus.ram_wea) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", {30'd0, bus.ram_addra}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                int  who;
                e = sb.pop_front();
                who = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : 2);
                chk("wr_who",  who,           e.who);
                chk("wr_addr", bus.ram_addra, e.addr);
                chk("wr_data", bus.ram_dina,  e.data);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 2'd1;
        bus.req0_data  = 8'hEE;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 2'd2;
        bus.req1_data  = 8'hEF;
        bus.clr_req    = 1'b1;
        bus.rdb_addr   = '0;
        bus.rdc_addr   = '0;

        // reset holds everything quiet even with requests pending
        repeat (2) @(posedge clk);
        samp();
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        chk("rst_ena",  bus.ram_ena, 0);
        chk("rst_wea",  bus.ram_wea, 0);
        chk("rst_busy", bus.clr_busy, 0);
        chk("rst_done", bus.clr_done, 0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.clr_req    = 1'b0;
        reset          = 1'b0;

        // single requester, same-cycle accept, read back next cycle
        step();
        bus.req0_valid = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 8'hA5;
        push(0, 1, 8'hA5);
        samp();
        chk("t1_rdy0", bus.req0_ready, 1);
        chk("t1_rdy1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        bus.rdb_addr   = 2'd1;
        samp();
        chk("t1_ena_idle", bus.ram_ena, 0);
        chk("t1_rdb", bus.rdb_data, 8'hA5);

        // fresh reset so req0 wins the first conflict
        step(); reset = 1'b1;
        step(); reset = 1'b0;

        // both valid for 4 cycles: alternate req0, req1
        bus.req0_valid = 1'b1; bus.req0_addr = 2'd0; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'h22;
        push(0, 0, 8'h11); push(1, 2, 8'h22); push(0, 0, 8'h11); push(1, 2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("t2_rdy0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("t2_rdy1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
            step();
        end

        // same address from both: req0 first (req1 had the last grant)
        bus.req0_addr = 2'd3; bus.req0_data = 8'h33;
        bus.req1_addr = 2'd3; bus.req1_data = 8'h44;
        push(0, 3, 8'h33); push(1, 3, 8'h44);
        samp();
        chk("t3_rdy0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        samp();
        chk("t3_rdy1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        bus.rdb_addr   = 2'd3;
        bus.rdc_addr   = 2'd2;
        samp();
        chk("t3_rdb_last_wins", bus.rdb_data, 8'h44);
        chk("t3_rdc", bus.rdc_data, 8'h22);

        // bypass of in-flight write on port B, stored data on port C
        step();
        bus.req1_valid = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'h5A;
        bus.rdb_addr   = 2'd2;
        bus.rdc_addr   = 2'd0;
        push(1, 2, 8'h5A);
        samp();
        chk("t4_rdy1", bus.req1_ready, 1);
        chk("t4_rdb_bypass", bus.rdb_data, 8'h5A);
        chk("t4_rdc_stored", bus.rdc_data, 8'h11);
        step();
        bus.req1_valid = 1'b0;
        samp();
        chk("t4_rdb_stored", bus.rdb_data, 8'h5A);

        // clear sweep; clr_req held during the sweep must be ignored
        step();
        bus.clr_req = 1'b1;
        samp();
        chk("t5_busy_pre", bus.clr_busy, 0);
        step();
        bus.req0_valid = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 8'hFF;
        bus.req1_valid = 1'b1; bus.req1_addr = 2'd1; bus.req1_data = 8'hFE;
        bus.rdb_addr   = 2'd2;
        for (int i = 0; i < 4; i++) push(2, i, 8'h00);
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("t5_busy", bus.clr_busy, 1);
            chk("t5_rdy0", bus.req0_ready, 0);
            chk("t5_rdy1", bus.req1_ready, 0);
            chk("t5_done_low", bus.clr_done, 0);
            chk("t5_rdb", bus.rdb_data, (i < 2) ? 8'h5A : 8'h00);
            step();
            if (i == 2) begin
                bus.clr_req    = 1'b0;
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        samp();
        chk("t5_done", bus.clr_done, 1);
        chk("t5_busy_post", bus.clr_busy, 0);
        chk("t5_ena_post", bus.ram_ena, 0);
        step();
        samp();
        chk("t5_done_once", bus.clr_done, 0);
        chk("t5_no_restart", bus.clr_busy, 0);
        for (int a = 0; a < 4; a++) begin
            step();
            bus.rdb_addr = AW'(a);
            bus.rdc_addr = AW'(3 - a);
            samp();
            chk("t5_rdb_cleared", bus.rdb_data, 8'h00);
            chk("t5_rdc_cleared", bus.rdc_data, 8'h00);
        end

        // reset during sweep cycle 2: abort, no clr_done, accept at once
        step();
        bus.clr_req = 1'b1;
        push(2, 0, 8'h00); push(2, 1, 8'h00);
        samp();
        step();
        bus.clr_req = 1'b0;
        samp();
        chk("t6_busy0", bus.clr_busy, 1);
        step();
        samp();
        chk("t6_busy1", bus.clr_busy, 1);
        step();
        reset = 1'b1;
        samp();
        chk("t6_rst_busy", bus.clr_busy, 0);
        chk("t6_rst_ena",  bus.ram_ena, 0);
        chk("t6_rst_done", bus.clr_done, 0);
        step();
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 8'h77;
        push(0, 1, 8'h77);
        samp();
        chk("t6_rdy0", bus.req0_ready, 1);
        chk("t6_busy", bus.clr_busy, 0);
        chk("t6_done", bus.clr_done, 0);
        step();
        bus.req0_valid = 1'b0;
        bus.rdb_addr   = 2'd1;
        samp();
        chk("t6_done_after", bus.clr_done, 0);
        chk("t6_rdb", bus.rdb_data, 8'h77);

        step();
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
